// File: rtl/uart_caesar_decipher_rx.sv
// Caesar decipher between UART RX strobe and consumer; 0x00 markers toggle an XOFF/XON pause.
// Latency: byte strobed in cycle N is visible at out_data/out_valid in N+1 (FIFO empty, running).
// Backpressure: out_valid/out_ready with FIFO buffering; none to UART, bytes dropped when full (sticky overflow).
// Optional CAESAR_DECIPHER_STATS_EN adds stat_letters / stat_markers counters.
module uart_caesar_decipher_rx #(
  parameter int SHIFT      = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        paused,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef CAESAR_DECIPHER_STATS_EN
  ,
  output logic [15:0]                 stat_letters,
  output logic [15:0]                 stat_markers
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] SH = 8'(SHIFT);

  typedef enum logic {RUNNING = 1'b0, PAUSED = 1'b1} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic is_marker;
  logic is_byte;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Shift letters back by SHIFT, wrapping within their own case; everything else untouched.
  function automatic logic [7:0] decipher(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    if (c >= 8'h41 && c <= 8'h5A)
      r = (c >= 8'h41 + SH) ? c - SH : c + 8'd26 - SH;
    else if (c >= 8'h61 && c <= 8'h7A)
      r = (c >= 8'h61 + SH) ? c - SH : c + 8'd26 - SH;
    return r;
  endfunction

  assign is_marker = rx_valid && (rx_data == 8'h00);
  assign is_byte   = rx_valid && (rx_data != 8'h00);
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the push needs.
  assign pop       = out_valid && out_ready;
  assign push      = is_byte && (!full || pop);
  assign drop      = is_byte && full && !pop;

  assign out_valid = (fifo_level != '0) && !paused;
  assign out_data  = mem[rd_ptr];

  // FIFO storage, pointers and occupancy; storage cleared so the head reads 0x00 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr_ptr] <= decipher(rx_data);
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Pause FSM: each marker flips RUNNING/PAUSED; paused is the registered state flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUNNING;
      paused <= 1'b0;
    end else if (is_marker) begin
      case (state)
        RUNNING: begin
          state  <= PAUSED;
          paused <= 1'b1;
        end
        default: begin
          state  <= RUNNING;
          paused <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef CAESAR_DECIPHER_STATS_EN
  logic is_letter;
  assign is_letter = (rx_data >= 8'h41 && rx_data <= 8'h5A) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h7A);

  // Saturating counts of letters actually written and of markers seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_letters <= '0;
      stat_markers <= '0;
    end else begin
      if (push && is_letter && stat_letters != 16'hFFFF) stat_letters <= stat_letters + 16'd1;
      if (is_marker && stat_markers != 16'hFFFF)         stat_markers <= stat_markers + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_caesar_decipher_rx.sv
// Bench for uart_caesar_decipher_rx: directed scenarios then randomized traffic
// compared against a queue-based model of the decipher FIFO and pause toggle.
module tb_uart_caesar_decipher_rx;

  localparam int SHIFT = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        paused;
  logic        overflow;
  logic        overflow_clr;
  logic [3:0]  fifo_level;
`ifdef CAESAR_DECIPHER_STATS_EN
  logic [15:0] stat_letters;
  logic [15:0] stat_markers;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_paused;
  logic       m_ovf;
  int         m_letters;
  int         m_markers;

  always #5 clk = ~clk;

  uart_caesar_decipher_rx #(.SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .paused(paused), .overflow(overflow), .overflow_clr(overflow_clr),
    .fifo_level(fifo_level)
`ifdef CAESAR_DECIPHER_STATS_EN
    , .stat_letters(stat_letters), .stat_markers(stat_markers)
`endif
  );

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  // Reference decode: position in the alphabet minus SHIFT, modulo 26.
  function automatic logic [7:0] ref_dec(input logic [7:0] c);
    int v;
    v = int'(c);
    if (c >= "A" && c <= "Z")      v = ((v - 65 - SHIFT + 26) % 26) + 65;
    else if (c >= "a" && c <= "z") v = ((v - 97 - SHIFT + 26) % 26) + 97;
    return 8'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0 && !m_paused));
    check("level", 32'(fifo_level), 32'(q.size()));
    check("paused", 32'(paused), 32'(m_paused));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
`ifdef CAESAR_DECIPHER_STATS_EN
    check("stat_letters", 32'(stat_letters), 32'(m_letters));
    check("stat_markers", 32'(stat_markers), 32'(m_markers));
`endif
  endtask

  // One clock: drive inputs, compare against model, advance model on the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    bit pop, isb, full, drop;
    rx_valid = v; rx_data = d; out_ready = rdy; overflow_clr = clr;
    #1;
    check_model();
    pop  = (q.size() > 0) && !m_paused && rdy;
    isb  = v && (d != 8'h00);
    full = (q.size() == DEPTH);
    drop = isb && full && !pop;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (v && d == 8'h00) begin
      m_paused = !m_paused;
      if (m_markers < 65535) m_markers++;
    end
    if (isb && !drop) begin
      q.push_back(ref_dec(d));
      if (is_alpha(d) && m_letters < 65535) m_letters++;
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; out_ready = 1'b0; overflow_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_paused = 1'b0; m_ovf = 1'b0; m_letters = 0; m_markers = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    int r;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // 'D','d' -> 'A','a' with one-cycle latency
    step(1'b1, 8'h44, 1'b1, 1'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_A", 32'(out_data), 32'h41);
    step(1'b1, 8'h64, 1'b1, 1'b0);
    check("t1_a", 32'(out_data), 32'h61);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_empty", 32'(fifo_level), 32'd0);

    // alphabet wrap and passthrough
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h63, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    check("t2_level", 32'(fifo_level), 32'd3);
    check("t2_X", 32'(out_data), 32'h58);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_z", 32'(out_data), 32'h7A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_bang", 32'(out_data), 32'h21);
    drain();

    // pause toggle
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h4B, 1'b1, 1'b0);
    step(1'b1, 8'h4C, 1'b1, 1'b0);
    check("t3_paused", 32'(paused), 32'd1);
    check("t3_valid", 32'(out_valid), 32'd0);
    check("t3_level", 32'(fifo_level), 32'd2);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("t3_resume", 32'(paused), 32'd0);
    check("t3_H", 32'(out_data), 32'h48);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_I", 32'(out_data), 32'h49);
    drain();

    // overflow on ninth byte, clear, ordered drain
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    check("t4_level", 32'(fifo_level), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_clr", 32'(overflow), 32'd0);
    drain();

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    check("t5_level", 32'(fifo_level), 32'd8);
    check("t5_ovf", 32'(overflow), 32'd0);
    drain();

    // reset while paused with 5 buffered
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("t6_pre_level", 32'(fifo_level), 32'd5);
    check("t6_pre_paused", 32'(paused), 32'd1);
    do_reset();
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_paused", 32'(paused), 32'd0);
`ifdef CAESAR_DECIPHER_STATS_EN
    check("t6_letters", 32'(stat_letters), 32'd0);
    check("t6_markers", 32'(stat_markers), 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      d = 8'h00;
      else if (r < 5)  d = 8'($urandom_range(8'h41, 8'h5A));
      else if (r < 8)  d = 8'($urandom_range(8'h61, 8'h7A));
      else             d = 8'($urandom_range(1, 255));
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    end
    if (m_paused) step(1'b1, 8'h00, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
